// File: rtl/motor_arm_controller.sv
// Arm/disarm sequencer between the receiver/PID front end and the motor mixer.
// Optional feature: define MOTOR_ARM_AUTO_DISARM_EN to disarm after a sustained low throttle in ARMED.
module motor_arm_controller #(
  parameter int                            RATE_WIDTH       = 16,
  parameter int                            UPDATE_DIV       = 20000,
  parameter int                            ARM_HOLD_TICKS   = 500,
  parameter int                            RX_TIMEOUT_TICKS = 100,
  parameter logic signed [RATE_WIDTH-1:0]  SPINUP_STEP      = RATE_WIDTH'(16),
  parameter logic signed [RATE_WIDTH-1:0]  IDLE_THROTTLE    = RATE_WIDTH'(16'h0100),
  parameter logic signed [RATE_WIDTH-1:0]  THROTTLE_ARM_MAX = RATE_WIDTH'(16'h0040),
  parameter int                            MIX_TIMEOUT      = 16
) (
  input  logic                         sys_clk,
  input  logic                         reset,
  input  logic                         arm_switch,
  input  logic                         rx_valid,
  input  logic signed [RATE_WIDTH-1:0] throttle_in,
  input  logic                         mix_done,
  output logic                         mix_start,
  output logic signed [RATE_WIDTH-1:0] throttle_out,
  output logic                         motors_enable,
  output logic                         armed,
  output logic [2:0]                   state_out,
  output logic                         overrun
);

  localparam int DIV_W = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
  localparam int RX_W  = $clog2(RX_TIMEOUT_TICKS + 1);
  localparam int ARM_W = $clog2(ARM_HOLD_TICKS + 1);
  localparam int MIX_W = $clog2(MIX_TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_ARMING   = 3'd1,
    ST_SPINUP   = 3'd2,
    ST_ARMED    = 3'd3,
    ST_FAILSAFE = 3'd4,
    ST_FAULT    = 3'd5
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div;
  logic [RX_W-1:0]  rx_wd;
  logic [ARM_W-1:0] arm_cnt;
  logic             busy;
  logic [MIX_W-1:0] busy_cnt;
  logic             tick;
  logic             rx_alive;
  logic             mix_timeout;
  logic             go_fault;

`ifdef MOTOR_ARM_AUTO_DISARM_EN
  localparam int AUTO_W = $clog2(2 * ARM_HOLD_TICKS + 1);
  logic [AUTO_W-1:0] auto_cnt;
`endif

  assign tick        = (div == DIV_W'(UPDATE_DIV - 1));
  assign rx_alive    = (rx_wd < RX_W'(RX_TIMEOUT_TICKS));
  // A pass counts as stalled once it has been in flight MIX_TIMEOUT cycles with no done.
  assign mix_timeout = busy && !mix_done && (busy_cnt == MIX_W'(MIX_TIMEOUT - 1));
  assign go_fault    = mix_timeout || (state == ST_FAULT);

  assign state_out     = state;
  assign motors_enable = (state inside {ST_SPINUP, ST_ARMED, ST_FAILSAFE});
  assign armed         = (state == ST_ARMED);

  // NOTE: every register here uses non-blocking assignment so all branches see pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state        <= ST_DISARMED;
      throttle_out <= '0;
      mix_start    <= 1'b0;
      overrun      <= 1'b0;
      div          <= '0;
      rx_wd        <= RX_W'(RX_TIMEOUT_TICKS);
      arm_cnt      <= '0;
      busy         <= 1'b0;
      busy_cnt     <= '0;
`ifdef MOTOR_ARM_AUTO_DISARM_EN
      auto_cnt     <= '0;
`endif
    end else begin
      div <= tick ? '0 : div + 1'b1;

      if (rx_valid)              rx_wd <= '0;
      else if (tick && rx_alive) rx_wd <= rx_wd + 1'b1;

      mix_start <= tick && !busy && !go_fault;
      if (mix_start) begin
        busy     <= 1'b1;
        busy_cnt <= MIX_W'(1);
      end else if (busy) begin
        if (mix_done) busy     <= 1'b0;
        else          busy_cnt <= busy_cnt + 1'b1;
      end

      if (go_fault)          overrun <= 1'b0;
      else if (tick && busy) overrun <= 1'b1;

`ifdef MOTOR_ARM_AUTO_DISARM_EN
      if (state != ST_ARMED) auto_cnt <= '0;
`endif

      if (go_fault) begin
        state        <= ST_FAULT;
        throttle_out <= '0;
      end else if (!arm_switch && (state inside {ST_SPINUP, ST_ARMED, ST_FAILSAFE})) begin
        state        <= ST_DISARMED;
        throttle_out <= '0;
      end else if (tick) begin
        unique case (state)
          ST_DISARMED: begin
            throttle_out <= '0;
            if (arm_switch && (throttle_in <= THROTTLE_ARM_MAX) && rx_alive) begin
              state   <= ST_ARMING;
              arm_cnt <= '0;
            end
          end
          ST_ARMING: begin
            if (!arm_switch || (throttle_in > THROTTLE_ARM_MAX) || !rx_alive) begin
              state <= ST_DISARMED;
            end else if (arm_cnt == ARM_W'(ARM_HOLD_TICKS - 1)) begin
              state <= ST_SPINUP;
            end else begin
              arm_cnt <= arm_cnt + 1'b1;
            end
          end
          ST_SPINUP: begin
            // Compare against IDLE - STEP so the ramp saturates without ever wrapping.
            if (throttle_out >= IDLE_THROTTLE - SPINUP_STEP) begin
              throttle_out <= IDLE_THROTTLE;
              state        <= ST_ARMED;
            end else begin
              throttle_out <= throttle_out + SPINUP_STEP;
            end
          end
          ST_ARMED: begin
`ifdef MOTOR_ARM_AUTO_DISARM_EN
            if (throttle_in > THROTTLE_ARM_MAX) auto_cnt <= '0;
            else                                auto_cnt <= auto_cnt + 1'b1;
`endif
            if (!rx_alive) begin
              state <= ST_FAILSAFE;
`ifdef MOTOR_ARM_AUTO_DISARM_EN
            end else if ((throttle_in <= THROTTLE_ARM_MAX) &&
                         (auto_cnt == AUTO_W'(2 * ARM_HOLD_TICKS - 1))) begin
              state        <= ST_DISARMED;
              throttle_out <= '0;
              auto_cnt     <= '0;
`endif
            end else begin
              throttle_out <= (throttle_in > IDLE_THROTTLE) ? throttle_in : IDLE_THROTTLE;
            end
          end
          ST_FAILSAFE: begin
            if (throttle_out <= SPINUP_STEP) begin
              throttle_out <= '0;
              state        <= ST_DISARMED;
            end else begin
              throttle_out <= throttle_out - SPINUP_STEP;
            end
          end
          ST_FAULT: ;
          default:  state <= ST_FAULT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_motor_arm_controller.sv
// Randomized bench for motor_arm_controller against a cycle-level arithmetic reference model.
module tb_motor_arm_controller;

  localparam int W      = 16;
  localparam int DIV    = 10;
  localparam int HOLD   = 4;
  localparam int RXTO   = 3;
  localparam int STEP   = 16;
  localparam int IDLE   = 'h40;
  localparam int AMAX   = 'h10;
  localparam int MTO    = 4;
  localparam int S_DIS  = 0;
  localparam int S_ARMG = 1;
  localparam int S_SPIN = 2;
  localparam int S_ARM  = 3;
  localparam int S_FS   = 4;
  localparam int S_FLT  = 5;

  logic                sys_clk;
  logic                reset, arm_switch, rx_valid, mix_done, mix_done2;
  logic signed [W-1:0] throttle_in;
  logic                mix_start, motors_enable, armed, overrun;
  logic signed [W-1:0] throttle_out;
  logic [2:0]          state_out;
  logic                mix_start2, motors_enable2, armed2, overrun2;
  logic signed [W-1:0] throttle_out2;
  logic [2:0]          state_out2;

  motor_arm_controller #(
    .RATE_WIDTH(W), .UPDATE_DIV(DIV), .ARM_HOLD_TICKS(HOLD), .RX_TIMEOUT_TICKS(RXTO),
    .SPINUP_STEP(16'sd16), .IDLE_THROTTLE(16'sh0040), .THROTTLE_ARM_MAX(16'sh0010),
    .MIX_TIMEOUT(MTO)
  ) dut (
    .sys_clk(sys_clk), .reset(reset), .arm_switch(arm_switch), .rx_valid(rx_valid),
    .throttle_in(throttle_in), .mix_done(mix_done), .mix_start(mix_start),
    .throttle_out(throttle_out), .motors_enable(motors_enable), .armed(armed),
    .state_out(state_out), .overrun(overrun)
  );

  // Second instance with a longer mixer timeout so a slow mixer shows overrun instead of FAULT.
  motor_arm_controller #(
    .RATE_WIDTH(W), .UPDATE_DIV(DIV), .ARM_HOLD_TICKS(HOLD), .RX_TIMEOUT_TICKS(RXTO),
    .SPINUP_STEP(16'sd16), .IDLE_THROTTLE(16'sh0040), .THROTTLE_ARM_MAX(16'sh0010),
    .MIX_TIMEOUT(16)
  ) dut_slow (
    .sys_clk(sys_clk), .reset(reset), .arm_switch(arm_switch), .rx_valid(rx_valid),
    .throttle_in(throttle_in), .mix_done(mix_done2), .mix_start(mix_start2),
    .throttle_out(throttle_out2), .motors_enable(motors_enable2), .armed(armed2),
    .state_out(state_out2), .overrun(overrun2)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;
  int rx_mode;
  int mix_delay;
  int done_at, done2_at;
  int starts_seen;
  bit chk_ovr;
  bit last_start;

  int m_state, m_thr, m_phase, m_silence, m_arm_ticks, m_launch;
  bit m_start, m_ovr, m_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = S_DIS; m_thr = 0; m_start = 0; m_ovr = 0; m_phase = 0;
    m_silence = RXTO; m_arm_ticks = 0; m_busy = 0; m_launch = 0;
  endtask

  // One clock edge of the reference behaviour, from current expectations plus driven inputs.
  task automatic model_advance(input bit arm, input bit rxv, input int thr, input bit md);
    bit tick, alive, timeout;
    int ns, nthr;
    tick    = (m_phase == DIV - 1);
    alive   = (m_silence < RXTO);
    timeout = m_busy && !md && (cyc - m_launch == MTO - 1);
    ns      = m_state;
    nthr    = m_thr;
    if (timeout || m_state == S_FLT) begin
      ns = S_FLT; nthr = 0;
    end else if (!arm && (m_state == S_SPIN || m_state == S_ARM || m_state == S_FS)) begin
      ns = S_DIS; nthr = 0;
    end else if (tick) begin
      case (m_state)
        S_DIS:  if (arm && thr <= AMAX && alive) begin ns = S_ARMG; m_arm_ticks = 0; end
        S_ARMG: if (!arm || thr > AMAX || !alive) ns = S_DIS;
                else begin
                  m_arm_ticks++;
                  if (m_arm_ticks == HOLD) ns = S_SPIN;
                end
        S_SPIN: begin
                  nthr = (m_thr + STEP > IDLE) ? IDLE : m_thr + STEP;
                  if (nthr == IDLE) ns = S_ARM;
                end
        S_ARM:  if (!alive) ns = S_FS;
                else nthr = (thr > IDLE) ? thr : IDLE;
        S_FS:   begin
                  nthr = (m_thr - STEP < 0) ? 0 : m_thr - STEP;
                  if (nthr == 0) ns = S_DIS;
                end
        default: ;
      endcase
    end
    m_ovr = (ns == S_FLT) ? 1'b0 : (m_ovr || (tick && m_busy));
    if (m_start) begin
      m_busy = 1; m_launch = cyc;
    end else if (m_busy && md) begin
      m_busy = 0;
    end
    m_start   = tick && !m_busy && m_state != S_FLT && !timeout;
    if (rxv)       m_silence = 0;
    else if (tick) m_silence = (m_silence + 1 > RXTO) ? RXTO : m_silence + 1;
    m_phase = (m_phase + 1) % DIV;
    m_state = ns;
    m_thr   = nthr;
  endtask

  task automatic compare_outputs();
    bit exp_en, exp_arm;
    exp_en  = (m_state == S_SPIN || m_state == S_ARM || m_state == S_FS);
    exp_arm = (m_state == S_ARM);
    check("state", {29'h0, state_out}, m_state);
    check("throttle", {16'h0, throttle_out}, m_thr);
    check("flags{start,ovr,en,armed}", {28'h0, mix_start, overrun, motors_enable, armed},
          {28'h0, m_start, m_ovr, exp_en, exp_arm});
  endtask

  task automatic step(input bit arm, input logic signed [W-1:0] thr);
    bit rxv, md, md2;
    compare_outputs();
    if (chk_ovr) begin
      if (cyc == 10) check("slow_first_start", {31'h0, mix_start2}, 1);
      if (cyc == 15) check("slow_overrun_clear", {31'h0, overrun2}, 0);
      if (cyc == 20) check("slow_start_skipped", {31'h0, mix_start2}, 0);
      if (cyc == 21) check("slow_overrun_set", {31'h0, overrun2}, 1);
      if (cyc == 30) check("slow_third_start", {31'h0, mix_start2}, 1);
    end
    // Mixer models respond to the pulses the DUTs actually emit.
    last_start = mix_start;
    if (mix_start) begin
      starts_seen++;
      if (mix_delay > 0) done_at = cyc + mix_delay;
    end
    if (mix_start2) done2_at = cyc + 12;
    md  = (cyc == done_at);
    md2 = (cyc == done2_at);
    case (rx_mode)
      0:       rxv = 1'b0;
      1:       rxv = (cyc % 10 == 3);
      default: rxv = ($urandom_range(0, 14) == 0);
    endcase
    arm_switch  = arm;
    rx_valid    = rxv;
    throttle_in = thr;
    mix_done    = md;
    mix_done2   = md2;
    model_advance(arm, rxv, int'(thr), md);
    cyc++;
    @(negedge sys_clk);
  endtask

  task automatic run(input int n, input bit arm, input logic signed [W-1:0] thr);
    for (int i = 0; i < n; i++) step(arm, thr);
  endtask

  task automatic do_reset();
    reset = 1'b1; arm_switch = 1'b0; rx_valid = 1'b0; throttle_in = '0;
    mix_done = 1'b0; mix_done2 = 1'b0;
    repeat (3) @(negedge sys_clk);
    reset = 1'b0;
    model_reset();
    cyc = 0; done_at = -1; done2_at = -1;
  endtask

  function automatic logic signed [W-1:0] rand_thr(input int kind);
    logic signed [W-1:0] edges [8];
    edges = '{16'sh0010, 16'sh0011, 16'sh0040, 16'sh0041,
              16'sh8000, 16'sh7FFF, 16'shFFFF, 16'sh0000};
    case (kind)
      0:       rand_thr = W'($urandom_range(0, 17));
      1:       rand_thr = W'($urandom_range(48, 80));
      2:       rand_thr = edges[$urandom_range(0, 7)];
      default: rand_thr = W'($urandom);
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "bench timeout");
  end

  initial begin
    int len, kind, r, s0;
    bit arm_r, found;
    logic signed [W-1:0] thr_r;

    rx_mode = 1; mix_delay = 2; chk_ovr = 1; starts_seen = 0;
    do_reset();
    check("rst_state", {29'h0, state_out}, 0);
    check("rst_throttle", {16'h0, throttle_out}, 0);
    check("rst_flags", {28'h0, mix_start, overrun, motors_enable, armed}, 0);

    // Arm sequence: four ARMING ticks, then a 0x10-step ramp to idle.
    run(50, 1, 16'sh0);
    check("spinup_entry", {29'h0, state_out}, S_SPIN);
    check("spinup_enable", {31'h0, motors_enable}, 1);
    run(10, 1, 16'sh0);
    check("spinup_step1", {16'h0, throttle_out}, 'h10);
    run(30, 1, 16'sh0);
    check("armed_entry", {29'h0, state_out}, S_ARM);
    check("armed_idle", {16'h0, throttle_out}, 'h40);
    check("armed_flag", {31'h0, armed}, 1);
    chk_ovr = 0;

    run(10, 1, 16'sh0200);
    check("pass_high", {16'h0, throttle_out}, 'h200);
    run(10, 1, 16'sh0020);
    check("pass_floor_idle", {16'h0, throttle_out}, 'h40);

    // Arm switch dropped between ticks takes effect on the next clock.
    run(3, 1, 16'sh0020);
    step(0, 16'sh0020);
    check("drop_state", {29'h0, state_out}, S_DIS);
    check("drop_throttle", {16'h0, throttle_out}, 0);

    // Abort after two ARMING ticks; re-arming needs the full hold again.
    run(26, 1, 16'sh0);
    check("abort_arming", {29'h0, state_out}, S_ARMG);
    run(10, 0, 16'sh0);
    check("abort_disarmed", {29'h0, state_out}, S_DIS);
    run(40, 1, 16'sh0);
    check("rearm_still_arming", {29'h0, state_out}, S_ARMG);
    run(10, 1, 16'sh0);
    check("rearm_spinup", {29'h0, state_out}, S_SPIN);
    run(40, 1, 16'sh0);
    check("rearm_armed", {29'h0, state_out}, S_ARM);

    // Receiver loss: failsafe ramp, recovered receiver does not cancel it.
    rx_mode = 0;
    run(30, 1, 16'sh0);
    check("rxloss_failsafe", {29'h0, state_out}, S_FS);
    check("rxloss_hold", {16'h0, throttle_out}, 'h40);
    run(5, 1, 16'sh0);
    rx_mode = 1;
    run(15, 1, 16'sh0);
    check("failsafe_ramp", {16'h0, throttle_out}, 'h20);
    check("failsafe_kept", {29'h0, state_out}, S_FS);
    run(20, 1, 16'sh0);
    check("failsafe_done", {29'h0, state_out}, S_DIS);
    check("failsafe_zero", {16'h0, throttle_out}, 0);
    run(10, 1, 16'sh0);
    check("rearm_via_disarmed", {29'h0, state_out}, S_ARMG);

    // Randomized segments: arm level, receiver behaviour and throttle region vary.
    for (int seg = 0; seg < 40; seg++) begin
      len   = $urandom_range(30, 200);
      arm_r = ($urandom_range(0, 9) != 0);
      r     = $urandom_range(0, 9);
      kind  = (r < 5) ? 0 : (r < 7) ? 1 : (r < 8) ? 2 : 3;
      r     = $urandom_range(0, 9);
      rx_mode = (r < 7) ? 1 : (r < 9) ? 2 : 0;
      thr_r = rand_thr(kind);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 9) == 0) thr_r = rand_thr(kind);
        step(arm_r, thr_r);
      end
    end

    // Mixer stall: no mix_done ever returns.
    rx_mode = 1; mix_delay = 0; found = 0;
    for (int i = 0; i < 25 && !found; i++) begin
      step(1, 16'sh0);
      found = last_start;
    end
    check("stall_start_seen", {31'h0, found}, 1);
    run(2, 1, 16'sh0);
    check("stall_not_yet_fault", {31'h0, (state_out == 3'd5)}, 0);
    run(1, 1, 16'sh0);
    check("stall_fault", {29'h0, state_out}, S_FLT);
    check("fault_outputs", {12'h0, throttle_out, mix_start, overrun, motors_enable, armed}, 0);
    s0 = starts_seen;
    run(40, 1, 16'sh0);
    check("fault_start_silent", starts_seen - s0, 0);
    check("fault_sticky", {29'h0, state_out}, S_FLT);

    mix_delay = 2;
    do_reset();
    check("reset_exits_fault", {29'h0, state_out}, S_DIS);
    run(10, 1, 16'sh0);
    check("post_reset_start", {31'h0, mix_start}, 1);
    run(5, 1, 16'sh0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
